// File: rtl/note_player.sv
// note_player: per-channel consumer of the pattern sequencer's note stream.
// It requests a note with a one-cycle strobe and latches the note when the
// sequencer answers. It then holds the note for (len+1) frame ticks. Gate,
// trigger, pitch and instrument go to one voice. A request that goes
// unanswered is retried after TIMEOUT cycles, and the sticky timeout flag
// is raised.
module note_player #(
  parameter int GATE_GAP = 2,   // ticks of gate-low at the end of a note; 0 = legato
  parameter int TIMEOUT  = 16   // cycles to wait for a note before re-requesting
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_tick,
  output logic       o_note_stb,
  input  logic       i_note_valid,
  input  logic [5:0] i_note_pitch,
  input  logic [4:0] i_note_len,
  input  logic [3:0] i_note_instrument,
  output logic       o_gate,
  output logic       o_trigger,
  output logic [5:0] o_pitch,
  output logic [3:0] o_instrument,
  output logic       o_timeout
);

  // Wait counter is wide enough to reach TIMEOUT-1; keep at least one bit.
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  // Gap threshold compared against a zero-extended 5-bit remain count.
  // Values above 32 behave identically to 32 (gate only on the first tick).
  localparam int GAP_C = (GATE_GAP > 32) ? 32 : ((GATE_GAP < 0) ? 0 : GATE_GAP);
  localparam logic [5:0] GAP_W = 6'(GAP_C);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQUEST   = 2'd1,
    ST_WAIT_NOTE = 2'd2,
    ST_PLAY      = 2'd3
  } state_e;

  // State and datapath registers with their next-state values
  state_e          state_q,   state_d;
  logic [4:0]      remain_q,  remain_d;
  logic [4:0]      len_q,     len_d;
  logic [WW-1:0]   wait_q,    wait_d;
  logic [5:0]      pitch_q,   pitch_d;
  logic [3:0]      instr_q,   instr_d;
  logic            timeout_q, timeout_d;

  // Registered voice-facing outputs
  logic            stb_q,     stb_d;
  logic            gate_q,    gate_d;
  logic            trigger_q, trigger_d;

  // A note is taken this cycle
  logic            accept_s;

  // Next-state and next-output computation for the note FSM
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    len_d     = len_q;
    wait_d    = wait_q;
    pitch_d   = pitch_q;
    instr_d   = instr_q;
    timeout_d = timeout_q;
    accept_s  = 1'b0;

    if (!i_enable) begin
      // Disable wins in every state. Any valid arriving now is dropped.
      // Pitch and instrument keep their last values.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQUEST;
        end

        ST_REQUEST: begin
          wait_d  = '0;
          state_d = ST_WAIT_NOTE;
        end

        ST_WAIT_NOTE: begin
          // A tick in the same cycle as the note is deliberately not counted.
          if (i_note_valid) begin
            accept_s = 1'b1;
            pitch_d  = i_note_pitch;
            instr_d  = i_note_instrument;
            remain_d = i_note_len;
            len_d    = i_note_len;
            state_d  = ST_PLAY;
          end else if (wait_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_REQUEST;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end

        ST_PLAY: begin
          // The tick that finds remain at zero ends the note.
          // That gives len+1 ticks in total.
          if (i_tick) begin
            if (remain_q == 5'd0) begin
              state_d = ST_REQUEST;
            end else begin
              remain_d = remain_q - 5'd1;
            end
          end else begin
            remain_d = remain_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are computed from next-state values so that the registered
    // copies line up with the state they describe.
    stb_d     = (state_d == ST_REQUEST);
    trigger_d = accept_s && (i_note_pitch != 6'd0);
    // The remain==len term keeps short notes gated for their first tick.
    if ((state_d == ST_PLAY) && (pitch_d != 6'd0)) begin
      gate_d = ({1'b0, remain_d} >= GAP_W) || (remain_d == len_d);
    end else begin
      gate_d = 1'b0;
    end
  end

  // Register FSM state, datapath and outputs; synchronous reset clears everything
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      remain_q  <= 5'd0;
      len_q     <= 5'd0;
      wait_q    <= '0;
      pitch_q   <= 6'd0;
      instr_q   <= 4'd0;
      timeout_q <= 1'b0;
      stb_q     <= 1'b0;
      gate_q    <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      len_q     <= len_d;
      wait_q    <= wait_d;
      pitch_q   <= pitch_d;
      instr_q   <= instr_d;
      timeout_q <= timeout_d;
      stb_q     <= stb_d;
      gate_q    <= gate_d;
      trigger_q <= trigger_d;
    end
  end

  assign o_note_stb   = stb_q;
  assign o_gate       = gate_q;
  assign o_trigger    = trigger_q;
  assign o_pitch      = pitch_q;
  assign o_instrument = instr_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player (GATE_GAP=2, TIMEOUT=16).
module tb_note_player;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       tick;
  logic       note_stb;
  logic       note_valid;
  logic [5:0] note_pitch;
  logic [4:0] note_len;
  logic [3:0] note_instr;
  logic       gate;
  logic       trigger;
  logic [5:0] pitch;
  logic [3:0] instr;
  logic       timeout;

  int n_vec;
  int n_miss;

  note_player #(.GATE_GAP(2), .TIMEOUT(16)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_enable          (enable),
    .i_tick            (tick),
    .o_note_stb        (note_stb),
    .i_note_valid      (note_valid),
    .i_note_pitch      (note_pitch),
    .i_note_len        (note_len),
    .i_note_instrument (note_instr),
    .o_gate            (gate),
    .o_trigger         (trigger),
    .o_pitch           (pitch),
    .o_instrument      (instr),
    .o_timeout         (timeout)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs held across it, outputs settled when it returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic send_note(input logic [5:0] p, input logic [4:0] l,
                           input logic [3:0] ins, input logic with_tick);
    note_valid = 1'b1;
    note_pitch = p;
    note_len   = l;
    note_instr = ins;
    tick       = with_tick;
    step();
    note_valid = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stb"},   note_stb, 0);
    check_val({tag, "_gate"},  gate,     0);
    check_val({tag, "_trig"},  trigger,  0);
    check_val({tag, "_pitch"}, pitch,    0);
    check_val({tag, "_instr"}, instr,    0);
    check_val({tag, "_tmo"},   timeout,  0);
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    tick       = 1'b0;
    note_valid = 1'b0;
    note_pitch = 6'd0;
    note_len   = 5'd0;
    note_instr = 4'd0;

    // 1: reset state, then first request
    steps(2);
    check_all_zero("rst");
    rst = 1'b0;
    step();
    check_val("idle_stb", note_stb, 0);
    enable = 1'b1;
    step();
    check_val("req1_stb", note_stb, 1);
    check_val("req1_gate", gate, 0);
    step();
    check_val("wait1_stb", note_stb, 0);
    check_val("wait1_trig", trigger, 0);
    steps(3);
    check_val("wait1_tmo", timeout, 0);

    // 2: pitch 12, len 3, instr 5
    send_note(6'd12, 5'd3, 4'd5, 1'b0);
    check_val("n1_trig", trigger, 1);
    check_val("n1_pitch", pitch, 12);
    check_val("n1_instr", instr, 5);
    check_val("n1_gate0", gate, 1);
    step();
    check_val("n1_trig_off", trigger, 0);
    check_val("n1_gate_hold", gate, 1);
    do_tick();
    check_val("n1_gate_t1", gate, 1);
    // valid during PLAY must be ignored
    send_note(6'd33, 5'd0, 4'd9, 1'b0);
    check_val("ign_pitch", pitch, 12);
    check_val("ign_instr", instr, 5);
    check_val("ign_trig", trigger, 0);
    do_tick();
    check_val("n1_gate_t2", gate, 0);
    do_tick();
    check_val("n1_gate_t3", gate, 0);
    check_val("n1_stb_t3", note_stb, 0);
    do_tick();
    check_val("n1_stb_t4", note_stb, 1);
    check_val("n1_gate_t4", gate, 0);

    // 3: rest, len 1
    step();
    steps(3);
    send_note(6'd0, 5'd1, 4'd3, 1'b0);
    check_val("rest_trig", trigger, 0);
    check_val("rest_gate", gate, 0);
    check_val("rest_pitch", pitch, 0);
    check_val("rest_instr", instr, 3);
    do_tick();
    check_val("rest_gate_t1", gate, 0);
    check_val("rest_stb_t1", note_stb, 0);
    do_tick();
    check_val("rest_stb_t2", note_stb, 1);

    // 4: no answer for 16 cycles -> timeout and retry
    steps(16);
    check_val("tmo_pre", timeout, 0);
    check_val("tmo_pre_stb", note_stb, 0);
    step();
    check_val("tmo_flag", timeout, 1);
    check_val("tmo_restb", note_stb, 1);
    step();

    // 5: valid and tick together; tick not counted (len 1 -> two more ticks)
    send_note(6'd20, 5'd1, 4'd2, 1'b1);
    check_val("vt_trig", trigger, 1);
    check_val("vt_gate", gate, 1);
    check_val("vt_pitch", pitch, 20);
    check_val("vt_tmo_sticky", timeout, 1);
    do_tick();
    check_val("vt_gate_t1", gate, 0);
    check_val("vt_stb_t1", note_stb, 0);
    do_tick();
    check_val("vt_stb_t2", note_stb, 1);
    step();
    // len 0: gated for its single tick
    send_note(6'd7, 5'd0, 4'd4, 1'b0);
    check_val("l0_gate", gate, 1);
    check_val("l0_trig", trigger, 1);
    step();
    check_val("l0_gate_hold", gate, 1);
    do_tick();
    check_val("l0_gate_end", gate, 0);
    check_val("l0_stb", note_stb, 1);

    // 6: disable mid-PLAY, late valid ignored, fresh request on re-enable
    step();
    send_note(6'd9, 5'd5, 4'd1, 1'b0);
    check_val("dis_gate_on", gate, 1);
    step();
    enable = 1'b0;
    step();
    check_val("dis_gate", gate, 0);
    check_val("dis_stb", note_stb, 0);
    check_val("dis_pitch", pitch, 9);
    send_note(6'd40, 5'd2, 4'd8, 1'b0);
    check_val("dis_late_pitch", pitch, 9);
    check_val("dis_late_instr", instr, 1);
    check_val("dis_late_trig", trigger, 0);
    check_val("dis_late_gate", gate, 0);
    enable = 1'b1;
    step();
    check_val("reen_stb", note_stb, 1);
    step();
    send_note(6'd11, 5'd4, 4'd6, 1'b0);
    check_val("pre_rst_gate", gate, 1);
    check_val("pre_rst_pitch", pitch, 11);
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
